block_slider: RTL and testbench
===============================

BLOCK_SLIDER -- requirements
Module: block_slider

Interface
REQ-001 Parameter COL_LAST, default 9: index of the rightmost playfield column.
REQ-002 Parameter BLK_LEN, default 3: block length in columns; 1 <= BLK_LEN <= COL_LAST+1.
REQ-003 Parameter BASE_SPEED, default 5000000: speed_count reload value for level 0, which gives 10 frames per second.
REQ-004 Parameter SPEED_STEP, default 416666: amount speed_count drops per placed block.
REQ-005 Parameter MIN_SPEED, default 833332: floor for speed_count.
REQ-006 clk  input  1  system clock; the only clock.
REQ-007 resetn  input  1  reset; asynchronous assert, active-low.
REQ-008 enable  input  1  game running; high allows sliding.
REQ-009 enable_frame  input  1  one-cycle frame tick from the frame delay counter.
REQ-010 place_req  input  1  one-cycle player "drop" pulse.
REQ-011 placed_ready  input  1  consumer accepts the placed block.
REQ-012 speed_count  output  32  reload value driven back to the frame delay counter.
REQ-013 col  output  4  leftmost column of the block.
REQ-014 dir  output  1  direction of travel; 1 = moving right.
REQ-015 placed_valid  output  1  placed block is presented on col/level.
REQ-016 level  output  4  count of placed blocks, saturating at 15.

Function
REQ-017 The FSM SHALL have 3 states: IDLE, SLIDE and HOLD.
REQ-018 IDLE SHALL go to SLIDE when enable=1.
REQ-019 SLIDE SHALL go to IDLE when enable=0; col and dir SHALL be held and sliding SHALL resume from them.
REQ-020 In SLIDE, place_req=1 SHALL go to HOLD on the next clock and set placed_valid=1.
REQ-021 In SLIDE, enable_frame=1 with place_req=0 SHALL move col by one in the direction given by dir; all other cycles SHALL hold col.
REQ-022 Bounce, with macro absent: at col = COL_LAST-BLK_LEN+1 with dir=1, a tick SHALL set dir=0 and col-1. At col=0 with dir=0, a tick SHALL set dir=1 and col+1.
REQ-023 place_req and enable_frame in the same SLIDE cycle: place SHALL win and col SHALL NOT move.
REQ-024 In HOLD, placed_valid SHALL stay 1 and col, dir, level and speed_count SHALL stay stable until placed_ready=1.
REQ-025 HOLD SHALL ignore enable, enable_frame and place_req.
REQ-026 The placed_valid & placed_ready cycle (acceptance) SHALL update four things on the same clock edge. placed_valid SHALL go to 0.
REQ-027 On acceptance, level SHALL increment, saturating at 15.
REQ-028 On acceptance, speed_count SHALL become max(speed_count-SPEED_STEP, MIN_SPEED), computed at 33 bits so there is no wrap.
REQ-029 On acceptance, col SHALL become 0 and dir SHALL become 1.
REQ-030 On acceptance, the next state SHALL be SLIDE if enable=1 and IDLE otherwise.
REQ-031 placed_valid SHALL be 1 only in HOLD.
REQ-032 Outputs SHALL be registered, with no combinational path from an input to an output.

Reset
REQ-033 resetn=0 SHALL immediately set state=IDLE, col=0, dir=1, placed_valid=0, level=0 and speed_count=BASE_SPEED.
REQ-034 Reset asserted mid-HOLD SHALL drop placed_valid with no acceptance side effects.
REQ-035 Release SHALL be synchronous to clk; the first active edge obeys IDLE rules.

Configuration
REQ-036 Macro SLIDER_WRAP_EN defined: at col = COL_LAST-BLK_LEN+1, a tick SHALL set col=0.
REQ-037 With SLIDER_WRAP_EN defined, dir SHALL be constant 1 and no leftward motion SHALL occur.
REQ-038 Macro SLIDER_WRAP_EN undefined: bounce behaviour per REQ-022.

Verification
REQ-039 Reset, then enable=1 and 8 ticks with defaults, bounce build: col SHALL run 0,1,...,7, then 6 with dir=0.
REQ-040 place_req and enable_frame in the same cycle at col=4: the next cycle SHALL show col=4 and placed_valid=1.
REQ-041 placed_ready held 0 for 10 cycles while ticks arrive: col=4, placed_valid=1 and speed_count=5000000 SHALL stay unchanged. Then placed_ready=1 for one cycle: level=1, speed_count=4583334, col=0, placed_valid=0.
REQ-042 11 placements: speed_count SHALL clamp at 833332. 16 or more placements: level SHALL stay at 15.
REQ-043 resetn pulsed low during HOLD with no clock edge: outputs SHALL show reset values at once.
REQ-044 Wrap build: at col=7, a tick SHALL give col=0 and dir=1.

Source files
------------

// File: rtl/block_slider.sv
// Sliding-block game core: a block of BLK_LEN columns slides across the playfield until placed.
// Define SLIDER_WRAP_EN to wrap from the right edge back to column 0 instead of bouncing.
module block_slider #(
  parameter int COL_LAST   = 9,
  parameter int BLK_LEN    = 3,
  parameter int BASE_SPEED = 5000000,
  parameter int SPEED_STEP = 416666,
  parameter int MIN_SPEED  = 833332
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        enable_frame,
  input  logic        place_req,
  input  logic        placed_ready,
  output logic [31:0] speed_count,
  output logic [3:0]  col,
  output logic        dir,
  output logic        placed_valid,
  output logic [3:0]  level
);

  typedef enum logic [1:0] {IDLE, SLIDE, HOLD} state_t;

  localparam logic [3:0] COL_RIGHT = 4'(COL_LAST - BLK_LEN + 1);

  state_t      state, state_next;
  logic [3:0]  col_next, level_next;
  logic        dir_next;
  logic [31:0] speed_next;
  logic [32:0] speed_diff;
  logic        accept, tick;

  assign accept = (state == HOLD) && placed_ready;
  assign tick   = (state == SLIDE) && enable && enable_frame && !place_req;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (enable) state_next = SLIDE;
      SLIDE: begin
        if (!enable)        state_next = IDLE;
        else if (place_req) state_next = HOLD;
      end
      HOLD:  if (placed_ready) state_next = enable ? SLIDE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values for the registered outputs; 33-bit subtraction keeps the speed floor wrap-free.
  always_comb begin
    col_next   = col;
    dir_next   = dir;
    level_next = level;
    speed_next = speed_count;
    speed_diff = {1'b0, speed_count} - 33'(SPEED_STEP);
    if (accept) begin
      level_next = (level == 4'd15) ? level : level + 4'd1;
      speed_next = (speed_diff[32] || speed_diff < 33'(MIN_SPEED)) ? 32'(MIN_SPEED)
                                                                   : speed_diff[31:0];
      col_next   = 4'd0;
      dir_next   = 1'b1;
    end else if (tick) begin
`ifdef SLIDER_WRAP_EN
      dir_next = 1'b1;
      col_next = (col == COL_RIGHT) ? 4'd0 : col + 4'd1;
`else
      if (dir) begin
        if (col == COL_RIGHT) begin
          dir_next = 1'b0;
          col_next = (col == 4'd0) ? col : col - 4'd1;
        end else begin
          col_next = col + 4'd1;
        end
      end else begin
        if (col == 4'd0) begin
          dir_next = 1'b1;
          col_next = (COL_RIGHT == 4'd0) ? col : col + 4'd1;
        end else begin
          col_next = col - 4'd1;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col          <= 4'd0;
      dir          <= 1'b1;
      level        <= 4'd0;
      speed_count  <= 32'(BASE_SPEED);
      placed_valid <= 1'b0;
    end else begin
      col          <= col_next;
      dir          <= dir_next;
      level        <= level_next;
      speed_count  <= speed_next;
      placed_valid <= (state_next == HOLD);
    end
  end

endmodule

// File: tb/tb_block_slider.sv
// Self-checking bench for block_slider: behavioural model feeds an expected-value queue.
// Honours SLIDER_WRAP_EN the same way the design does.
module tb_block_slider;

  localparam int COL_RIGHT = 7;
  localparam int M_IDLE = 0, M_SLIDE = 1, M_HOLD = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0, enable_frame = 1'b0, place_req = 1'b0, placed_ready = 1'b0;
  logic [31:0] speed_count;
  logic [3:0]  col, level;
  logic        dir, placed_valid;

  typedef struct {
    int     col;
    int     dir;
    int     level;
    longint speed;
    int     valid;
  } exp_t;

  exp_t   exp_q[$];
  int     tests_run = 0;
  int     tests_failed = 0;
  int     m_state, m_col, m_dir, m_level, m_valid;
  longint m_speed;

  block_slider dut (
    .clk(clk), .resetn(resetn), .enable(enable), .enable_frame(enable_frame),
    .place_req(place_req), .placed_ready(placed_ready), .speed_count(speed_count),
    .col(col), .dir(dir), .placed_valid(placed_valid), .level(level)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_state = M_IDLE; m_col = 0; m_dir = 1; m_level = 0; m_speed = 5000000; m_valid = 0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_col"}, 32'(col), 32'd0);
    checkOutput({tag, "_dir"}, 32'(dir), 32'd1);
    checkOutput({tag, "_valid"}, 32'(placed_valid), 32'd0);
    checkOutput({tag, "_level"}, 32'(level), 32'd0);
    checkOutput({tag, "_speed"}, speed_count, 32'd5000000);
  endtask

  task automatic modelMove();
`ifdef SLIDER_WRAP_EN
    m_col = (m_col == COL_RIGHT) ? 0 : m_col + 1;
`else
    if (m_dir == 1) begin
      if (m_col == COL_RIGHT) begin m_dir = 0; m_col = m_col - 1; end
      else m_col = m_col + 1;
    end else begin
      if (m_col == 0) begin m_dir = 1; m_col = 1; end
      else m_col = m_col - 1;
    end
`endif
  endtask

  // Drive one cycle of inputs, push the model's prediction, then compare after the edge.
  task automatic applyStimulus(input logic en, input logic ef, input logic pr, input logic rdy);
    exp_t e;
    @(negedge clk);
    enable = en; enable_frame = ef; place_req = pr; placed_ready = rdy;
    case (m_state)
      M_IDLE:  if (en) m_state = M_SLIDE;
      M_SLIDE: begin
        if (!en)     m_state = M_IDLE;
        else if (pr) m_state = M_HOLD;
        else if (ef) modelMove();
      end
      default: if (rdy) begin
        if (m_level < 15) m_level = m_level + 1;
        m_speed = m_speed - 416666;
        if (m_speed < 833332) m_speed = 833332;
        m_col = 0; m_dir = 1;
        m_state = en ? M_SLIDE : M_IDLE;
      end
    endcase
    m_valid = (m_state == M_HOLD) ? 1 : 0;
    e.col = m_col; e.dir = m_dir; e.level = m_level; e.speed = m_speed; e.valid = m_valid;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checkOutput("col", 32'(col), 32'(e.col));
    checkOutput("dir", 32'(dir), 32'(e.dir));
    checkOutput("level", 32'(level), 32'(e.level));
    checkOutput("speed", speed_count, 32'(e.speed));
    checkOutput("valid", 32'(placed_valid), 32'(e.valid));
  endtask

  initial begin
    int guard;
    int en_bit;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    @(negedge clk);
    resetn = 1'b1;

    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 0);
`ifdef SLIDER_WRAP_EN
    checkOutput("wrap_col", 32'(col), 32'd0);
    checkOutput("wrap_dir", 32'(dir), 32'd1);
`else
    checkOutput("bounce_col", 32'(col), 32'd6);
    checkOutput("bounce_dir", 32'(dir), 32'd0);
`endif

    // Pause with enable low: col and dir must be held, then sliding resumes.
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);

    guard = 0;
    while (m_col != 4 && guard < 20) begin
      applyStimulus(1, 1, 0, 0);
      guard++;
    end
    checkOutput("reach_col4", 32'(col), 32'd4);

    applyStimulus(1, 1, 1, 0);
    checkOutput("place_win_col", 32'(col), 32'd4);
    checkOutput("place_win_valid", 32'(placed_valid), 32'd1);

    for (int i = 0; i < 10; i++) applyStimulus(1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), 0);
    checkOutput("hold_col", 32'(col), 32'd4);
    checkOutput("hold_speed", speed_count, 32'd5000000);

    applyStimulus(1, 0, 0, 1);
    checkOutput("accept_level", 32'(level), 32'd1);
    checkOutput("accept_speed", speed_count, 32'd4583334);
    checkOutput("accept_col", 32'(col), 32'd0);
    checkOutput("accept_valid", 32'(placed_valid), 32'd0);

    // Sixteen more placements drive speed to its floor and level into saturation.
    for (int p = 0; p < 16; p++) begin
      applyStimulus(1, 0, 0, 0);
      for (int t = 0; t < 1 + p % 4; t++) applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 0, 1, 0);
      applyStimulus(1, 1, 0, 0);
      en_bit = $urandom_range(0, 1);
      applyStimulus(1'(en_bit), 0, 0, 1);
      if (p == 9) checkOutput("speed_11", speed_count, 32'd833332);
    end
    checkOutput("level_sat", 32'(level), 32'd15);
    checkOutput("speed_floor", speed_count, 32'd833332);

    // Asynchronous reset in the middle of HOLD, sampled between edges.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0);
    checkOutput("pre_rst_valid", 32'(placed_valid), 32'd1);
    #2;
    resetn = 1'b0;
    placed_ready = 1'b1;
    #1;
    checkResetValues("async_rst");
    modelReset();
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(0, 1, 1, 1);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) == 0));
    end
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
